// File: rtl/vga_pkg.sv
// Shared constants, op codes and writer state encoding for the VGA frame RAM write side.
package vga_pkg;

   localparam int H_ACTIVE = 800;
   localparam int V_ACTIVE = 480;
   localparam int ADDR_W   = 19;
   localparam int COORD_W  = 11;
   localparam int COLOR_W  = 3;

   localparam logic OP_PIXEL = 1'b0;
   localparam logic OP_FILL  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PIXEL = 2'd1,
      ST_FILL  = 2'd2
   } writer_state_t;

   function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                      input logic [COORD_W-1:0] max_v);
      return (v > max_v) ? max_v : v;
   endfunction

endpackage

// File: rtl/vga_frame_writer_if.sv
// Command handshake bus into the frame writer: drawing logic is master, engine is slave.
interface vga_frame_writer_if;
   import vga_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_op;
   logic [COORD_W-1:0] cmd_x0;
   logic [COORD_W-1:0] cmd_y0;
   logic [COORD_W-1:0] cmd_x1;
   logic [COORD_W-1:0] cmd_y1;
   logic [COLOR_W-1:0] cmd_color;
   logic               busy;

   modport master (
      output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
      input  cmd_ready, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
      output cmd_ready, busy
   );

endinterface

// File: rtl/vga_pixel_addr.sv
// Combinational (x,y) -> frame RAM address, y*H_ACTIVE + x truncated to ADDR_W.
module vga_pixel_addr #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int ADDR_W   = vga_pkg::ADDR_W
) (
   input  logic [vga_pkg::COORD_W-1:0] x,
   input  logic [vga_pkg::COORD_W-1:0] y,
   output logic [ADDR_W-1:0]           addr
);
   import vga_pkg::*;

   logic [ADDR_W-1:0] x_ext;
   logic [ADDR_W-1:0] y_ext;

   assign x_ext = ADDR_W'(x);
   assign y_ext = ADDR_W'(y);

   // 800 = 512 + 256 + 32, so the standard mode needs only adders
   generate
      if (H_ACTIVE == 800) begin : g_shift_add
         assign addr = (y_ext << 9) + (y_ext << 8) + (y_ext << 5) + x_ext;
      end else begin : g_mult
         assign addr = y_ext * ADDR_W'(H_ACTIVE) + x_ext;
      end
   endgenerate

endmodule

// File: rtl/vga_frame_writer.sv
// Turns PIXEL / FILL commands into one frame RAM write per clock.
// Rectangle fill is built only when VGA_FRAME_WRITER_FILL_EN is defined.
module vga_frame_writer #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int ADDR_W   = vga_pkg::ADDR_W
) (
   input  logic                           clk,
   input  logic                           reset,
   vga_frame_writer_if.slave              cmd,
   output logic [ADDR_W-1:0]              ram_write_address,
   output logic [vga_pkg::COLOR_W-1:0]    ram_d,
   output logic                           ram_we
);
   import vga_pkg::*;

   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

   writer_state_t      state_reg, state_next;
   logic [ADDR_W-1:0]  addr_reg, addr_next;
   logic [COLOR_W-1:0] color_reg, color_next;
   logic [ADDR_W-1:0]  start_addr;
   logic               pixel_off;

   vga_pixel_addr #(
      .H_ACTIVE (H_ACTIVE),
      .ADDR_W   (ADDR_W)
   ) u_start_addr (
      .x    (cmd.cmd_x0),
      .y    (cmd.cmd_y0),
      .addr (start_addr)
   );

   assign pixel_off = (cmd.cmd_x0 > X_MAX) || (cmd.cmd_y0 > Y_MAX);

`ifdef VGA_FRAME_WRITER_FILL_EN
   logic [COORD_W-1:0] x_reg, x_next, x0_reg, x0_next, x1_reg, x1_next;
   logic [COORD_W-1:0] y_reg, y_next, y1_reg, y1_next;
   logic [ADDR_W-1:0]  row_start_reg, row_start_next;
   logic [COORD_W-1:0] x1_clamped, y1_clamped;
   logic               fill_empty;

   assign x1_clamped = clamp_coord(cmd.cmd_x1, X_MAX);
   assign y1_clamped = clamp_coord(cmd.cmd_y1, Y_MAX);
   assign fill_empty = pixel_off || (x1_clamped < cmd.cmd_x0) || (y1_clamped < cmd.cmd_y0);
`endif

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      color_next = color_reg;
`ifdef VGA_FRAME_WRITER_FILL_EN
      x_next         = x_reg;
      x0_next        = x0_reg;
      x1_next        = x1_reg;
      y_next         = y_reg;
      y1_next        = y1_reg;
      row_start_next = row_start_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (cmd.cmd_valid) begin
               color_next = cmd.cmd_color;
               addr_next  = start_addr;
`ifdef VGA_FRAME_WRITER_FILL_EN
               if (cmd.cmd_op == OP_FILL) begin
                  x_next         = cmd.cmd_x0;
                  x0_next        = cmd.cmd_x0;
                  x1_next        = x1_clamped;
                  y_next         = cmd.cmd_y0;
                  y1_next        = y1_clamped;
                  row_start_next = start_addr;
                  if (!fill_empty) state_next = ST_FILL;
               end else if (!pixel_off) begin
                  state_next = ST_PIXEL;
               end
`else
               if (!pixel_off) state_next = ST_PIXEL;
`endif
            end
         end
         ST_PIXEL: state_next = ST_IDLE;
`ifdef VGA_FRAME_WRITER_FILL_EN
         ST_FILL: begin
            // row_start tracks the address of (x0, y), so a row step is one add
            if (x_reg == x1_reg) begin
               if (y_reg == y1_reg) begin
                  state_next = ST_IDLE;
               end else begin
                  y_next         = y_reg + 1'b1;
                  x_next         = x0_reg;
                  row_start_next = row_start_reg + ADDR_W'(H_ACTIVE);
                  addr_next      = row_start_reg + ADDR_W'(H_ACTIVE);
               end
            end else begin
               x_next    = x_reg + 1'b1;
               addr_next = addr_reg + 1'b1;
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         color_reg <= '0;
`ifdef VGA_FRAME_WRITER_FILL_EN
         x_reg         <= '0;
         x0_reg        <= '0;
         x1_reg        <= '0;
         y_reg         <= '0;
         y1_reg        <= '0;
         row_start_reg <= '0;
`endif
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         color_reg <= color_next;
`ifdef VGA_FRAME_WRITER_FILL_EN
         x_reg         <= x_next;
         x0_reg        <= x0_next;
         x1_reg        <= x1_next;
         y_reg         <= y_next;
         y1_reg        <= y1_next;
         row_start_reg <= row_start_next;
`endif
      end
   end

   assign cmd.cmd_ready     = (state_reg == ST_IDLE);
   assign cmd.busy          = (state_reg != ST_IDLE);
   assign ram_we            = (state_reg != ST_IDLE);
   assign ram_write_address = addr_reg;
   assign ram_d             = color_reg;

endmodule

// File: tb/tb_vga_frame_writer.sv
// Table-driven bench for vga_frame_writer with a write scoreboard; adapts expectations
// to whether VGA_FRAME_WRITER_FILL_EN is defined.
module tb_vga_frame_writer;
   import vga_pkg::*;

`ifdef VGA_FRAME_WRITER_FILL_EN
   localparam bit FILL_BUILD = 1'b1;
`else
   localparam bit FILL_BUILD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] ram_write_address;
   logic [2:0]        ram_d;
   logic              ram_we;

   vga_frame_writer_if bus ();

   vga_frame_writer dut (
      .clk               (clk),
      .reset             (reset),
      .cmd               (bus.slave),
      .ram_write_address (ram_write_address),
      .ram_d             (ram_d),
      .ram_we            (ram_we)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       op;
      int         x0, y0, x1, y1;
      logic [2:0] color;
      int         n_fill, last_fill;
      int         n_pix, last_pix;
   } vec_t;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   vec_t vecs [11];
   wr_t  sb_q [$];
   int   checks = 0;
   int   errors = 0;
   int   wr_count = 0;
   int   last_addr = -1;
   bit   sb_en = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference: every written pixel, in raster order, using a plain multiply
   task automatic push_expected(input vec_t v);
      int xa, xb, ya, yb;
      xa = v.x0;
      ya = v.y0;
      if (FILL_BUILD && v.op) begin
         xb = (v.x1 > 799) ? 799 : v.x1;
         yb = (v.y1 > 479) ? 479 : v.y1;
      end else begin
         xb = v.x0;
         yb = v.y0;
         if (xa > 799 || ya > 479) xb = -1;
      end
      for (int y = ya; y <= yb; y++)
         for (int x = xa; x <= xb; x++)
            sb_q.push_back('{y * 800 + x, int'(v.color)});
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (sb_en && !reset && ram_we === 1'b1) begin
         wr_count++;
         last_addr = int'(ram_write_address);
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d d=%0d required=no write", ram_write_address, ram_d);
         end else begin
            e = sb_q.pop_front();
            if (int'(ram_write_address) != e.addr || int'(ram_d) != e.data) begin
               errors++;
               $display("FAIL sb_write addr=%0d d=%0d required addr=%0d d=%0d",
                        ram_write_address, ram_d, e.addr, e.data);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 with the engine idle again
   task automatic run_cmd(input vec_t v, input int idx);
      int    n0, k, exp_n, exp_last;
      string tag;
      tag      = $sformatf("v%0d", idx);
      exp_n    = FILL_BUILD ? v.n_fill : v.n_pix;
      exp_last = FILL_BUILD ? v.last_fill : v.last_pix;
      push_expected(v);
      n0 = wr_count;
      check({tag, "_ready_before"}, 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = v.op;
      bus.cmd_x0    = 11'(v.x0);
      bus.cmd_y0    = 11'(v.y0);
      bus.cmd_x1    = 11'(v.x1);
      bus.cmd_y1    = 11'(v.y1);
      bus.cmd_color = v.color;
      @(posedge clk); #1;
      // keep valid up with a different command while busy: it must be ignored
      bus.cmd_op    = OP_PIXEL;
      bus.cmd_x0    = 11'd20;
      bus.cmd_y0    = 11'd20;
      bus.cmd_color = 3'd1;
      check({tag, "_busy_n1"}, 32'(bus.busy), (exp_n > 0) ? 32'd1 : 32'd0);
      k = 1;
      while (bus.cmd_ready !== 1'b1 && k <= 2000) begin
         @(posedge clk); #1;
         k++;
      end
      bus.cmd_valid = 1'b0;
      check({tag, "_ready_cycle"}, 32'(k), 32'(exp_n + 1));
      check({tag, "_write_count"}, 32'(wr_count - n0), 32'(exp_n));
      if (exp_n > 0) check({tag, "_last_addr"}, 32'(last_addr), 32'(exp_last));
      check({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   initial begin
      vec_t pv;
      vecs[0]  = '{1'b0,  10,   2,    0,   0, 3'd5,  1,   1610, 1,   1610};
      vecs[1]  = '{1'b1, 798,   0,  801,   1, 3'd7,  4,   1599, 1,    798};
      vecs[2]  = '{1'b0, 800,   5,    0,   0, 3'd3,  0,      0, 0,      0};
      vecs[3]  = '{1'b1,   5,   3,    2,   7, 3'd1,  0,      0, 1,   2405};
      vecs[4]  = '{1'b1,   0, 479,    2, 600, 3'd2,  3, 383202, 1, 383200};
      vecs[5]  = '{1'b0, 799, 479,    0,   0, 3'd6,  1, 383999, 1, 383999};
      vecs[6]  = '{1'b1,   3,   1,    5,   3, 3'd4,  9,   2405, 1,    803};
      vecs[7]  = '{1'b0,   0, 480,    0,   0, 3'd1,  0,      0, 0,      0};
      vecs[8]  = '{1'b1, 900,   0, 1000,   5, 3'd5,  0,      0, 0,      0};
      vecs[9]  = '{1'b1,   7,   7,    7,   7, 3'd3,  1,   5607, 1,   5607};
      vecs[10] = '{1'b1,   4,   4,    9,   9, 3'd6, 36,   7209, 1,   3204};

      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 1'b0;
      bus.cmd_x0    = '0;
      bus.cmd_y0    = '0;
      bus.cmd_x1    = '0;
      bus.cmd_y1    = '0;
      bus.cmd_color = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_we",    32'(ram_we), 32'd0);
      check("rst_addr",  32'(ram_write_address), 32'd0);
      check("rst_d",     32'(ram_d), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run_cmd(vecs[i], i);

      // Dropped command followed by an accept on the very next edge
      pv = '{1'b0, 1, 1, 0, 0, 3'd2, 1, 801, 1, 801};
      push_expected(pv);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_PIXEL;
      bus.cmd_x0    = 11'd800;
      bus.cmd_y0    = 11'd5;
      bus.cmd_color = 3'd3;
      @(posedge clk); #1;
      check("drop_ready_kept", 32'(bus.cmd_ready), 32'd1);
      check("drop_no_we", 32'(ram_we), 32'd0);
      bus.cmd_x0    = 11'd1;
      bus.cmd_y0    = 11'd1;
      bus.cmd_color = 3'd2;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check("b2b_we", 32'(ram_we), 32'd1);
      check("b2b_addr", 32'(ram_write_address), 32'd801);
      check("b2b_d", 32'(ram_d), 32'd2);
      @(posedge clk); #1;
      check("b2b_ready_n2", 32'(bus.cmd_ready), 32'd1);
      check("b2b_sb_drained", 32'(sb_q.size()), 32'd0);
      sb_q.delete();

      // Reset in the middle of a long fill
      sb_en = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_FILL;
      bus.cmd_x0    = 11'd0;
      bus.cmd_y0    = 11'd0;
      bus.cmd_x1    = 11'd799;
      bus.cmd_y1    = 11'd9;
      bus.cmd_color = 3'd3;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check("midfill_we", 32'(ram_we), FILL_BUILD ? 32'd1 : 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_we",    32'(ram_we), 32'd0);
      check("midrst_ready", 32'(bus.cmd_ready), 32'd1);
      check("midrst_busy",  32'(bus.busy), 32'd0);
      check("midrst_addr",  32'(ram_write_address), 32'd0);
      check("midrst_d",     32'(ram_d), 32'd0);
      reset = 1'b0;
      sb_q.delete();
      sb_en = 1'b1;
      @(posedge clk); #1;
      check("postrst_idle_we", 32'(ram_we), 32'd0);
      run_cmd(vecs[0], 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
